// File: rtl/instruction_fetch_memory.sv
// Synchronous-read instruction memory: cleared after reset, loaded through a
// programming port, then serves byte-addressed fetches through a valid-tagged pipeline.
module instruction_fetch_memory #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_address,
  output logic                  fetch_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  addr_error,
  input  logic                  prog_en,
  input  logic [31:0]           prog_address,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_done,
  input  logic                  reload,
  output logic                  load_error,
  output logic [1:0]            mem_state
);

  localparam int unsigned AW = $clog2(MEMORY_DEPTH);
  localparam int unsigned PL = READ_LATENCY;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  logic [AW-1:0]         r_cnt;
  logic                  r_fetch_ready;
  logic                  r_load_error;
  logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];

  // Stage 0 is the synchronous memory read; stage PL drives the outputs.
  logic                  r_pv [PL+1];
  logic                  r_pe [PL+1];
  logic [DATA_WIDTH-1:0] r_pd [PL+1];

  logic [31:0]           w_off;
  logic                  w_fetch_err;
  logic [AW-1:0]         w_fetch_idx;
  logic                  w_accept;
  logic                  w_prog_ok;
  logic                  w_inflight;
  logic                  w_mem_we;
  logic [AW-1:0]         w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  // Addresses below the base wrap to large offsets and fail the range test.
  assign w_off       = fetch_address - BASE_ADDRESS;
  assign w_fetch_err = (w_off[1:0] != 2'b00) || (w_off[31:AW+2] != '0);
  assign w_fetch_idx = w_off[AW+1:2];
  assign w_accept    = fetch_req && r_fetch_ready;
  assign w_prog_ok   = (prog_address[31:AW] == '0);

  always_comb begin
    w_inflight = 1'b0;
    for (int k = 0; k < PL; k++) begin
      w_inflight = w_inflight | r_pv[k];
    end
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_cnt;
    w_mem_wdata = '0;
    if (r_state == S_CLEAR) begin
      w_mem_we = 1'b1;
    end else if (r_state == S_LOAD && prog_en && w_prog_ok) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = prog_address[AW-1:0];
      w_mem_wdata = prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_CLEAR;
      r_cnt         <= '0;
      r_fetch_ready <= 1'b0;
      r_load_error  <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == AW'(MEMORY_DEPTH - 1)) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (prog_en && !w_prog_ok) begin
            r_load_error <= 1'b1;
          end
          if (prog_done) begin
            r_state       <= S_RUN;
            r_fetch_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (reload) begin
            r_state       <= S_DRAIN;
            r_fetch_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!w_inflight) begin
            r_state      <= S_CLEAR;
            r_cnt        <= '0;
            r_load_error <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_CLEAR;
          r_fetch_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= PL; k++) begin
        r_pv[k] <= 1'b0;
        r_pe[k] <= 1'b0;
        r_pd[k] <= '0;
      end
    end else begin
      r_pv[0] <= w_accept;
      r_pe[0] <= w_accept && w_fetch_err;
      r_pd[0] <= (w_accept && !w_fetch_err) ? r_mem[w_fetch_idx] : '0;
      for (int k = 1; k <= PL; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pe[k] <= r_pe[k-1];
        r_pd[k] <= r_pd[k-1];
      end
    end
  end

  assign fetch_ready = r_fetch_ready;
  assign instr_valid = r_pv[PL];
  assign instruction = r_pd[PL];
  assign addr_error  = r_pe[PL];
  assign load_error  = r_load_error;
  assign mem_state   = r_state;

endmodule
